mul_rill: RTL and testbench
===========================

Name: mul_rill

Overview:
Sequential shift-add multiply-accumulate block, the inverse of the team's restoring divider. It takes a quotient, divisor and remainder and rebuilds the dividend as q*b + r, one multiplier bit per clock. It uses a start/busy/done handshake and also checks that the remainder is well-formed (r < b). It serves as the reconstruction and check engine behind the divider, both in hardware and in the divider's self-check bench.

Parameters:
WIDTH, 16, operand width of q, b and r; result is 2*WIDTH.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only while idle.
q  input  WIDTH  quotient (multiplier); sampled with start.
b  input  WIDTH  divisor (multiplicand); sampled with start.
r  input  WIDTH  remainder (accumulator seed); sampled with start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; result and rem_ok are valid and updated.
result  output  2*WIDTH  q*b + r.
rem_ok  output  1  1 when the captured r < captured b.
cnt  output  8  iteration counter; exposed for simulation.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, result=0, rem_ok=0, cnt=0; internal registers cleared. Asserting reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: wait for start.
  - RUN: WIDTH iterations, then return to IDLE.
  - No separate DONE state; done is a registered pulse.
- IDLE, start=1 at edge k:
  - mq <= q.
  - mb <= {WIDTH zeros, b} (2*WIDTH wide).
  - acc <= {WIDTH zeros, r}.
  - rok <= (r < b), unsigned compare.
  - cnt <= 0; busy <= 1; go to RUN.
- RUN, each edge:
  - if mq[0]=1 then acc <= acc + mb; the add is 2*WIDTH wide with no carry-out; q*b+r ≤ 2^(2W)-2^W, so it cannot overflow.
  - mb <= mb<<1; mq <= mq>>1; cnt <= cnt+1.
- Final RUN edge (cnt=WIDTH-1), edge k+WIDTH:
  - result <= final accumulator, including this iteration's add.
  - rem_ok <= rok; done <= 1; busy <= 0; go to IDLE.
- Latency: done is high in the cycle after edge k+WIDTH (16 clocks after start is sampled for WIDTH=16). done is deasserted on the next edge.
- start while busy=1 is ignored; inputs may change freely during RUN.
- start high in the done cycle is accepted (state is IDLE); this gives back-to-back throughput of one result per WIDTH+1 clocks.
- result and rem_ok hold their value between done pulses. They change only at completion, never at start.
- Boundary cases:
  - b=0: result=r, rem_ok=0.
  - q=0: result=r.
  - r ≥ b: arithmetic is still exact; only rem_ok=0.
- Holding start continuously restarts immediately after each done.

Test Plan:
- q=142, b=7, r=6, start one cycle → done exactly 16 clocks later, result=32'd1000, rem_ok=1, busy high for those 16 cycles.
- q=16'hFFFF, b=16'hFFFF, r=16'hFFFE → result=32'hFFFEFFFF, rem_ok=1 (max-value, no overflow).
- q=5, b=0, r=9 → result=9, rem_ok=0. Then q=3, b=4, r=4 → result=16, rem_ok=0.
- Start 1000/7 operands, then pulse start with q=1, b=1, r=0 at cycle 5 of RUN → second start ignored, result=1000, single done.
- rst_n low at cycle 8 of RUN → busy=0, done=0, result=0 immediately (asynchronous). After release, q=10, b=10, r=3 → result=103.
- Start held high with a new operand set in the done cycle → second done exactly 17 clocks after the first, both results correct; result stable between pulses.

Source files
------------

// File: rtl/mul_rill.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_rill : sequential shift-add multiply-accumulate, result = q*b + r,
//            one multiplier bit per clock, plus a remainder check (r < b).
// Revision : 1.0
// ---------------------------------------------------------------------------
module mul_rill #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               rem_ok,
  output logic [7:0]         cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [7:0] LAST   = 8'(WIDTH - 1);

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [2*WIDTH-1:0] mb_q, mb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               rok_q, rok_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               rem_ok_q, rem_ok_d;
  logic [2*WIDTH-1:0] acc_sum;

  // q*b + r never exceeds 2^(2W) - 2^W, so dropping the carry-out is safe
  assign acc_sum = mq_q[0] ? (acc_q + mb_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    mq_d     = mq_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    rok_d    = rok_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    rem_ok_d = rem_ok_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        mq_d    = q;
        mb_d    = {{WIDTH{1'b0}}, b};
        acc_d   = {{WIDTH{1'b0}}, r};
        rok_d   = (r < b);
        cnt_d   = 8'd0;
        busy_d  = 1'b1;
        state_d = S_RUN;
      end
    end else begin
      acc_d = acc_sum;
      mb_d  = mb_q << 1;
      mq_d  = mq_q >> 1;
      cnt_d = cnt_q + 8'd1;
      // Last iteration: publish including this cycle's partial product
      if (cnt_q == LAST) begin
        result_d = acc_sum;
        rem_ok_d = rok_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mq_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      rok_q    <= 1'b0;
      cnt_q    <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rem_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mq_q     <= mq_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      rok_q    <= rok_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rem_ok_q <= rem_ok_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rem_ok = rem_ok_q;
  assign cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_rill.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_rill : directed scoreboard bench for mul_rill.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_mul_rill;

  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] res;
    logic           ok;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   q = '0, b = '0, r = '0;
  logic           busy, done, rem_ok;
  logic [2*W-1:0] result;
  logic [7:0]     cnt;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  mul_rill #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q(q), .b(b), .r(r),
    .busy(busy), .done(done), .result(result), .rem_ok(rem_ok), .cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("rem_ok", 64'(rem_ok), 64'(e.ok));
        chk("cnt_at_done", 64'(cnt), 64'(W));
      end
    end
  end

  // Present operands with start; returns 1ns after the sampling edge
  task automatic issue(input logic [W-1:0] qi, bi, ri, input logic [2*W-1:0] er,
                       input logic eo, input bit push, input bit drop);
    exp_t e;
    q = qi; b = bi; r = ri; start = 1'b1;
    if (push) begin
      e.res = er; e.ok = eo;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (drop) start = 1'b0;
  endtask

  // Counts edges until done is seen; n = W means done right on schedule
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = busy ? 1 : 0;
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (!done && busy) nbusy++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within 64 cycles");
    end
  endtask

  initial begin
    int n, nb;
    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_rem_ok", 64'(rem_ok), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 142*7+6 = 1000, latency and busy length
    issue(16'd142, 16'd7, 16'd6, 32'd1000, 1'b1, 1'b1, 1'b1);
    wait_done(n, nb);
    chk("latency_1000", 64'(n), 64'd16);
    chk("busy_cycles", 64'(nb), 64'd16);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);

    // Max operands, no overflow
    issue(16'hFFFF, 16'hFFFF, 16'hFFFE, 32'hFFFEFFFF, 1'b1, 1'b1, 1'b1);
    wait_done(n, nb);
    repeat (2) @(posedge clk);
    #1;

    // b = 0 and r >= b
    issue(16'd5, 16'd0, 16'd9, 32'd9, 1'b0, 1'b1, 1'b1);
    wait_done(n, nb);
    @(posedge clk); #1;
    issue(16'd3, 16'd4, 16'd4, 32'd16, 1'b0, 1'b1, 1'b1);
    wait_done(n, nb);
    @(posedge clk); #1;

    // start during RUN is ignored
    issue(16'd142, 16'd7, 16'd6, 32'd1000, 1'b1, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    q = 16'd1; b = 16'd1; r = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, nb);
    repeat (25) @(posedge clk);
    #1;
    chk("result_held", 64'(result), 64'd1000);

    // Asynchronous reset mid-operation
    issue(16'd142, 16'd7, 16'd6, 32'd0, 1'b0, 1'b0, 1'b1);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_cnt", 64'(cnt), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(16'd10, 16'd10, 16'd3, 32'd103, 1'b1, 1'b1, 1'b1);
    wait_done(n, nb);
    @(posedge clk); #1;

    // Back-to-back with start held: second op captured in the done cycle
    issue(16'd100, 16'd50, 16'd49, 32'd5049, 1'b1, 1'b1, 1'b0);
    wait_done(n, nb);
    issue(16'd1234, 16'd321, 16'd320, 32'd396434, 1'b1, 1'b1, 1'b1);
    begin
      int k;
      k = 0;
      while (!done && k < 64) begin
        chk("b2b_hold", 64'(result), 64'd5049);
        @(posedge clk); #1;
        k++;
      end
      chk("b2b_gap", 64'(k + 1), 64'd17);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
